nibble_add_scheduler: RTL and testbench

NIBBLE_ADD_SCHEDULER -- requirements
Module: nibble_add_scheduler

---
 rtl/nibble_add_scheduler_pkg.sv | 12 +
 rtl/nibble_add_scheduler_slice.sv | 14 +
 rtl/nibble_add_scheduler.sv | 115 +++++++++++
 tb/tb_nibble_add_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_add_scheduler_pkg.sv
// Shared definitions for the nibble-serial add scheduler: FSM encoding and slice width.
package nibble_add_scheduler_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add_scheduler_slice.sv
// Shared 4-bit full-adder slice; the only adder in the scheduler datapath.
module four_bit_full_adder_module
  import nibble_add_scheduler_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_add_scheduler.sv
// Two-requester add scheduler: round-robin grant, then one nibble per cycle
// through a single shared 4-bit slice, LSB first, result held until taken.
module nibble_add_scheduler
  import nibble_add_scheduler_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req0_valid,
  input  logic [NIBBLE_W*NIBBLES-1:0]  req0_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  req0_b,
  input  logic                         req0_cin,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [NIBBLE_W*NIBBLES-1:0]  req1_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  req1_b,
  input  logic                         req1_cin,
  output logic                         req1_ready,
  output logic                         resp_valid,
  output logic                         resp_id,
  output logic [NIBBLE_W*NIBBLES-1:0]  resp_sum,
  output logic                         resp_cout,
  input  logic                         resp_ready
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t               state, state_next;
  logic [W-1:0]         op_a, op_b;
  logic [IDX_W-1:0]     idx;
  logic                 carry;
  logic                 last_grant;
  logic                 grant_any;
  logic                 grant_id;
  logic                 accept;
  logic [NIBBLE_W-1:0]  slice_a, slice_b, slice_sum;
  logic                 slice_cout;

  // Round-robin: on contention the requester not granted last wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_any)        state_next = CALC;
      CALC:    if (idx == LAST_IDX)  state_next = DONE;
      DONE:    if (resp_ready)       state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  always_comb begin
    accept     = rst_n && (state == IDLE) && grant_any;
    req0_ready = accept && !grant_id;
    req1_ready = accept &&  grant_id;
    resp_valid = (state == DONE);
  end

  assign slice_a = op_a[NIBBLE_W*idx +: NIBBLE_W];
  assign slice_b = op_b[NIBBLE_W*idx +: NIBBLE_W];

  four_bit_full_adder_module u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      last_grant <= 1'b1;
      resp_id    <= 1'b0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            op_a       <= grant_id ? req1_a   : req0_a;
            op_b       <= grant_id ? req1_b   : req0_b;
            carry      <= grant_id ? req1_cin : req0_cin;
            resp_id    <= grant_id;
            last_grant <= grant_id;
            idx        <= '0;
          end
        end
        CALC: begin
          resp_sum[NIBBLE_W*idx +: NIBBLE_W] <= slice_sum;
          carry <= slice_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) resp_cout <= slice_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_scheduler.sv
// Randomized and directed bench for nibble_add_scheduler against a transaction-level model.
module tb_nibble_add_scheduler;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_cin, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_cin, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic         resp_valid, resp_id, resp_cout, resp_ready;
  logic [W-1:0] resp_sum;

  always #5 clk = ~clk;

  nibble_add_scheduler #(.NIBBLES(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .resp_ready (resp_ready)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  // Transaction-level reference: free/busy, when the result becomes visible, and its value.
  bit           m_busy = 1'b0;
  bit           m_last = 1'b1;
  int unsigned  m_valid_from = 0;
  logic [W-1:0] m_sum;
  logic         m_cout, m_id;
  int unsigned  acc_q[$];
  bit           id_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit e0, e1, erv;
    e0 = 1'b0;
    e1 = 1'b0;
    if (rst_n && !m_busy) begin
      if (req0_valid && req1_valid) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
    check_eq("req0_ready", req0_ready, e0);
    check_eq("req1_ready", req1_ready, e1);
    if (req0_ready || req1_ready) acc_q.push_back(cyc);
    erv = m_busy && (cyc >= m_valid_from);
    if (rst_n) begin
      check_eq("resp_valid", resp_valid, erv);
      if (erv) begin
        check_eq("resp_sum", resp_sum, m_sum);
        check_eq("resp_cout", resp_cout, m_cout);
        check_eq("resp_id", resp_id, m_id);
      end
      if (resp_valid && resp_ready) id_q.push_back(resp_id);
    end
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = 1'b1;
    end else if (e0 || e1) begin
      m_id   = e1;
      m_last = e1;
      if (e1) {m_cout, m_sum} = {1'b0, req1_a} + {1'b0, req1_b} + {{W{1'b0}}, req1_cin};
      else    {m_cout, m_sum} = {1'b0, req0_a} + {1'b0, req0_b} + {{W{1'b0}}, req0_cin};
      m_busy       = 1'b1;
      m_valid_from = cyc + N + 1;
    end else if (erv && resp_ready) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_req(input bit id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_cin = c;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_cin = c;
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (m_busy && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic directed(input string tag, input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W-1:0] xs, input logic xc);
    int unsigned n;
    logic rdy;
    resp_ready = 1'b1;
    set_req(id, 1'b1, a, b, c);
    #1;
    n = 0;
    rdy = id ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      tick();
      #1;
      rdy = id ? req1_ready : req0_ready;
      n++;
    end
    check_eq({tag, "_grant"}, rdy, 1'b1);
    tick();
    set_req(id, 1'b0, '0, '0, 1'b0);
    n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_latency"}, n, N);
    check_eq({tag, "_sum"}, resp_sum, xs);
    check_eq({tag, "_cout"}, resp_cout, xc);
    check_eq({tag, "_id"}, resp_id, id);
    tick();
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int unsigned  lim;

    rst_n = 1'b0;
    resp_ready = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    check_eq("reset_valid", resp_valid, 1'b0);
    check_eq("reset_sum", resp_sum, '0);
    check_eq("reset_cout", resp_cout, 1'b0);
    check_eq("reset_id", resp_id, 1'b0);

    directed("add_basic", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    directed("add_wrap",  1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    directed("add_cin",   1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);

    // Continuous contention: ids must alternate starting with requester 0.
    acc_q.delete();
    id_q.delete();
    resp_ready = 1'b1;
    set_req(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
    set_req(1'b1, 1'b1, W'($urandom), W'($urandom), 1'($urandom));
    repeat (4 * (N + 2) + 2) tick();
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    drain();
    check_eq("rr_count", (id_q.size() >= 4 && acc_q.size() >= 4), 1'b1);
    lim = (id_q.size() < 4) ? id_q.size() : 4;
    for (int unsigned i = 0; i < lim; i++) check_eq("rr_id", id_q[i], i % 2);
    lim = (acc_q.size() < 4) ? acc_q.size() : 4;
    for (int unsigned i = 1; i < lim; i++) check_eq("rr_gap", acc_q[i] - acc_q[i-1], N + 2);

    // Stall in DONE: outputs stay put and neither requester is accepted.
    resp_ready = 1'b0;
    set_req(1'b0, 1'b1, 16'h0F0F, 16'h00F1, 1'b1);
    tick();
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    lim = 0;
    while (!resp_valid && lim < 20) begin
      tick();
      lim++;
    end
    set_req(1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0);
    set_req(1'b1, 1'b1, W'($urandom), W'($urandom), 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      check_eq("stall_valid", resp_valid, 1'b1);
      check_eq("stall_sum", resp_sum, 16'h1001);
      check_eq("stall_cout", resp_cout, 1'b0);
      check_eq("stall_rdy", {req0_ready, req1_ready}, 2'b00);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check_eq("stall_valid4", resp_valid, 1'b1);
    tick();
    #1;
    check_eq("post_stall_rr", {req0_ready, req1_ready}, 2'b01);
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    #1;
    tick();

    // Reset mid-CALC: no response, and req0 wins the next contention.
    set_req(1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0);
    tick();
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("rst_rdy", {req0_ready, req1_ready}, 2'b00);
    tick();
    rst_n = 1'b1;
    for (int unsigned i = 0; i < N + 2; i++) begin
      #1;
      check_eq("rst_no_resp", resp_valid, 1'b0);
      tick();
    end
    set_req(1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0);
    set_req(1'b1, 1'b1, W'($urandom), W'($urandom), 1'b0);
    #1;
    check_eq("rst_first_grant", {req0_ready, req1_ready}, 2'b10);
    tick();
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    drain();

    // Random traffic with occasional resets and carry-heavy operands.
    repeat (2000) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int unsigned r = 0; r < 2; r++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        if ($urandom_range(0, 7) == 0) ra = '1;
        set_req(r[0], 1'($urandom_range(0, 2) != 0), ra, rb, 1'($urandom));
      end
      tick();
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
